clock_ctrl: RTL and testbench

Front-end controller for the digital clock. It sits directly upstream of the time-keeping counter.
- Conditions the three raw DE2 push-buttons (mode, up, down): synchronise, debounce.
- Runs the setting-mode FSM.
- Generates the 1 Hz run tick (sec_en) and the 5 Hz auto-repeat tick (en_5hz).
- Outputs feed the counter's sec_en, en_5hz, mode, up and down inputs directly.

---
 rtl/clock_ctrl.sv | 168 ++++++++++++++++
 tb/tb_clock_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// clock_ctrl: front end of the digital clock. Conditions the three raw
// push-buttons (2-flop synchroniser + debounce), runs the setting-mode FSM
// and produces the 1 Hz run tick and the 5 Hz auto-repeat tick.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous reset, active-high
//   mode_btn_n  raw mode key, active-low, asynchronous, bouncy
//   up_btn_n    raw up key, active-low, asynchronous, bouncy
//   down_btn_n  raw down key, active-low, asynchronous, bouncy
//   sec_en      one-cycle run tick every SEC_DIV clocks, only in RUN
//   en_5hz      one-cycle setting tick while up/down held, only outside RUN
//   mode        00 run, 01 set seconds, 10 set minutes, 11 set hours
//   up          debounced up key level, active-low
//   down        debounced down key level, active-low
module clock_ctrl #(
  parameter int unsigned SEC_DIV      = 50_000_000,
  parameter int unsigned FAST_DIV     = 10_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn_n,
  input  logic       up_btn_n,
  input  logic       down_btn_n,
  output logic       sec_en,
  output logic       en_5hz,
  output logic [1:0] mode,
  output logic       up,
  output logic       down
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned SEC_W  = (SEC_DIV > 1)      ? $clog2(SEC_DIV)      : 1;
  localparam int unsigned FAST_W = (FAST_DIV > 1)     ? $clog2(FAST_DIV)     : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_DIV - 1);
  localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_DIV - 1);

  // Key lane indices into the per-key vectors below
  localparam int unsigned K_MODE = 0;
  localparam int unsigned K_UP   = 1;
  localparam int unsigned K_DOWN = 2;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_SEC  = 2'b01,
    SET_MIN  = 2'b10,
    SET_HOUR = 2'b11
  } mode_t;

  logic [2:0]      raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      stable;
  logic [2:0]      stable_d;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [3];

  mode_t state;
  mode_t state_next;

  logic [SEC_W-1:0]  sec_cnt;
  logic              sec_hit;
  logic [FAST_W-1:0] fast_cnt;
  logic              fast_hit;
  logic              key_held;

  assign raw = {down_btn_n, up_btn_n, mode_btn_n};

  // Synchroniser and debounce. A key level is accepted only after the
  // synchronised input has differed from the stable level for DEBOUNCE_CYC
  // consecutive cycles; any return to the stable level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '1;
      sync2    <= '1;
      stable   <= '1;
      stable_d <= '1;
      db_cnt   <= '{default: '0};
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Press strobe: stable level just went 1 -> 0; releases are ignored
  assign press = stable_d & ~stable;

  assign up   = stable[K_UP];
  assign down = stable[K_DOWN];

  // Mode FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Mode FSM: next state, one step per mode-key press
  always_comb begin
    state_next = state;
    if (press[K_MODE]) begin
      case (state)
        RUN:      state_next = SET_SEC;
        SET_SEC:  state_next = SET_MIN;
        SET_MIN:  state_next = SET_HOUR;
        SET_HOUR: state_next = RUN;
      endcase
    end
  end

  // Mode FSM: output
  always_comb begin
    mode = state;
  end

  // 1 Hz prescaler: frozen at zero while setting, so the first tick after
  // returning to RUN comes a full SEC_DIV cycles later. A tick that lands on
  // a mode press is dropped because the clock is leaving RUN.
  assign sec_hit = (sec_cnt == SEC_LAST);

  always_ff @(posedge clk) begin
    if (rst || state != RUN) begin
      sec_cnt <= '0;
      sec_en  <= 1'b0;
    end else begin
      sec_cnt <= sec_hit ? '0 : sec_cnt + SEC_W'(1);
      sec_en  <= sec_hit && !press[K_MODE];
    end
  end

  // 5 Hz auto-repeat: immediate pulse on a press, then one every FAST_DIV
  // cycles while either key is held. A mode change restarts the interval.
  assign key_held = ~(stable[K_UP] & stable[K_DOWN]);
  assign fast_hit = (fast_cnt == FAST_LAST);

  always_ff @(posedge clk) begin
    if (rst || state == RUN || press[K_MODE]) begin
      fast_cnt <= '0;
      en_5hz   <= 1'b0;
    end else if (press[K_UP] || press[K_DOWN]) begin
      fast_cnt <= '0;
      en_5hz   <= 1'b1;
    end else if (key_held) begin
      fast_cnt <= fast_hit ? '0 : fast_cnt + FAST_W'(1);
      en_5hz   <= fast_hit;
    end else begin
      fast_cnt <= '0;
      en_5hz   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with SEC_DIV=10, FAST_DIV=4, DEBOUNCE_CYC=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_clock_ctrl;

  logic       clk;
  logic       rst;
  logic       mode_btn_n;
  logic       up_btn_n;
  logic       down_btn_n;
  logic       sec_en;
  logic       en_5hz;
  logic [1:0] mode;
  logic       up;
  logic       down;

  int checks   = 0;
  int failures = 0;

  clock_ctrl #(
    .SEC_DIV      (10),
    .FAST_DIV     (4),
    .DEBOUNCE_CYC (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_btn_n (mode_btn_n),
    .up_btn_n   (up_btn_n),
    .down_btn_n (down_btn_n),
    .sec_en     (sec_en),
    .en_5hz     (en_5hz),
    .mode       (mode),
    .up         (up),
    .down       (down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until a sec_en pulse (prescaler is then at 0), bounded
  task automatic sync_to_sec();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (sec_en === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("sync_sec_en", found, 1);
  endtask

  initial begin
    rst        = 1'b1;
    mode_btn_n = 1'b1;
    up_btn_n   = 1'b1;
    down_btn_n = 1'b1;
    tick();
    tick();
    check("rst_mode", mode, 0);
    check("rst_sec_en", sec_en, 0);
    check("rst_en_5hz", en_5hz, 0);
    check("rst_up", up, 1);
    check("rst_down", down, 1);
    rst = 1'b0;

    // Run mode, no keys: ticks at 10, 20, 30 cycles after reset release
    for (int i = 1; i <= 30; i++) begin
      tick();
      check("s1_sec_en", sec_en, (i % 10 == 0));
      check("s1_en_5hz", en_5hz, 0);
    end
    check("s1_mode", mode, 0);
    check("s1_up", up, 1);
    check("s1_down", down, 1);

    // Bouncy up key, then clean low: accepted 5 clocks after the final edge
    for (int i = 0; i < 8; i++) begin
      up_btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      check("s2_bounce_up", up, 1);
    end
    up_btn_n = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      tick();
      check("s2_fall_up", up, (j >= 5) ? 0 : 1);
      check("s2_no_rep_in_run", en_5hz, 0);
    end
    up_btn_n = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check("s2_rise_up", up, (j >= 5) ? 1 : 0);
    end

    // Four mode presses: 01, 10, 11, 00; mode changes 6 clocks after raw press
    sync_to_sec();
    for (int p = 0; p < 4; p++) begin
      mode_btn_n = 1'b0;
      for (int j = 1; j <= 10; j++) begin
        tick();
        check("s3_mode_press", mode, (j >= 6) ? (p + 1) % 4 : p);
        check("s3_sec_en_press", sec_en, 0);
        check("s3_en_5hz", en_5hz, 0);
      end
      mode_btn_n = 1'b1;
      for (int j = 1; j <= 10; j++) begin
        tick();
        check("s3_mode_release", mode, (p + 1) % 4);
        check("s3_sec_en_release", sec_en, (p == 3 && j == 6));
      end
    end

    // Mode press strobe lands on prescaler count 9: that tick is dropped
    mode_btn_n = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("s6_mode", mode, (j >= 6) ? 1 : 0);
      check("s6_sec_en_dropped", sec_en, 0);
    end
    mode_btn_n = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("s6_mode_hold", mode, 1);
      check("s6_sec_en_frozen", sec_en, 0);
    end

    // Set seconds, down held for 20 cycles: pulses at 6, 10, 14, 18, 22
    down_btn_n = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      if (j == 21) down_btn_n = 1'b1;
      tick();
      check("s4_en_5hz", en_5hz, (j == 6 || j == 10 || j == 14 || j == 18 || j == 22));
      check("s4_down", down, (j >= 5 && j < 25) ? 0 : 1);
      check("s4_sec_en", sec_en, 0);
    end
    check("s4_mode", mode, 1);

    // Move to set minutes, hold up until repeat counter is at 2, then reset
    mode_btn_n = 1'b0;
    repeat (10) tick();
    mode_btn_n = 1'b1;
    repeat (10) tick();
    check("s5_mode_min", mode, 2);
    up_btn_n = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      check("s5_en_5hz", en_5hz, (j == 6));
    end
    rst = 1'b1;
    tick();
    check("s5_rst_mode", mode, 0);
    check("s5_rst_up", up, 1);
    check("s5_rst_en_5hz", en_5hz, 0);
    check("s5_rst_sec_en", sec_en, 0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("s5_post_mode", mode, 0);
      check("s5_post_en_5hz", en_5hz, 0);
      check("s5_post_sec_en", sec_en, 0);
      check("s5_post_up", up, (k >= 5) ? 0 : 1);
    end
    up_btn_n = 1'b1;
    repeat (6) tick();
    check("s5_final_up", up, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
